word_mul: RTL

Word-serial integer multiplier that forms the full double-width product C = A·B consumed by the Montgomery reduction stage (`mod_red`) directly downstream. Each cycle it multiplies the full Q_LEN-bit A by one R-bit digit of B and accumulates the result, so a product takes Q_LEN/R cycles. It wraps that datapath in valid/ready handshakes on both sides. Default widths match the reducer: Q_LEN=64 and R=32 give K=128.

---
 rtl/monty_pkg.sv | 16 +
 rtl/word_mul_if.sv | 23 ++
 rtl/word_mul_row_mul.sv | 17 +
 rtl/word_mul.sv | 91 +++++++++
 4 files changed

// File: rtl/monty_pkg.sv
// rtl/monty_pkg.sv - shared constants, state type and digit-count helper for the Montgomery datapath
package monty_pkg;

    localparam int MONTY_R = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_t;

    function automatic int digit_count(input int q_len, input int r = MONTY_R);
        return q_len / r;
    endfunction

endpackage

// File: rtl/word_mul_if.sv
// rtl/word_mul_if.sv - operand/product handshake bundle for word_mul
interface word_mul_if #(
    parameter int Q_LEN = 64,
    parameter int K     = 2 * Q_LEN
);
    logic             in_valid;
    logic             in_ready;
    logic [Q_LEN-1:0] A;
    logic [Q_LEN-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     C;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, C
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, C
    );
endinterface

// File: rtl/word_mul_row_mul.sv
// rtl/word_mul_row_mul.sv - combinational Q_LEN x R unsigned row multiplier
module row_mul #(
    parameter int Q_LEN = 64,
    parameter int R     = 32
) (
    input  logic [Q_LEN-1:0]   a,
    input  logic [R-1:0]       b,
    output logic [Q_LEN+R-1:0] p
);
    // Widen both operands so the product is computed at full precision.
    logic [Q_LEN+R-1:0] a_ext;
    logic [Q_LEN+R-1:0] b_ext;

    assign a_ext = {{R{1'b0}}, a};
    assign b_ext = {{Q_LEN{1'b0}}, b};
    assign p     = a_ext * b_ext;
endmodule

// File: rtl/word_mul.sv
// rtl/word_mul.sv - word-serial multiplier, MS digit of B first, valid/ready on both sides
module word_mul
    import monty_pkg::*;
#(
    parameter int Q_LEN = 64,
    parameter int R     = MONTY_R,
    parameter int K     = 2 * Q_LEN
) (
    input  logic        clk,
    input  logic        rst,
    word_mul_if.slave   bus
);
    localparam int D     = digit_count(Q_LEN, R);
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

    if (Q_LEN % R != 0) begin : g_bad_digit
        $error("word_mul: Q_LEN must be a multiple of R");
    end
    if (K != 2 * Q_LEN) begin : g_bad_width
        $error("word_mul: K must be 2*Q_LEN");
    end

    mul_state_t         state;
    logic [Q_LEN-1:0]   a_q;
    logic [Q_LEN-1:0]   b_q;
    logic [K-1:0]       acc;
    logic [CNT_W-1:0]   cnt;
    logic               out_valid_q;
    logic [Q_LEN+R-1:0] row;

    row_mul #(.Q_LEN(Q_LEN), .R(R)) u_row_mul (
        .a (a_q),
        .b (b_q[Q_LEN-1 -: R]),
        .p (row)
    );

    // in_ready follows out_ready combinationally so DONE can hand straight over to MUL.
    assign bus.in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign bus.out_valid = out_valid_q;
    assign bus.C         = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= (acc << R) + K'(row);
                    b_q <= b_q << R;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(D - 1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q   <= bus.A;
                            b_q   <= bus.B;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
